// File: rtl/q_update_engine.sv
// Sequential Q-learning update engine: scans the s' row for max/argmax, computes
// Q(s,a) += alpha*(target - Q(s,a)) in saturating signed fixed point, writes back.
module q_update_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_STATES  = 16,
  parameter int NUM_ACTIONS = 4,
  localparam int SW = $clog2(NUM_STATES),
  localparam int AW = $clog2(NUM_ACTIONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SW-1:0]         in_state,
  input  logic [AW-1:0]         in_action,
  input  logic [SW-1:0]         in_next_state,
  input  logic [DATA_WIDTH-1:0] in_reward,
  input  logic                  in_terminal,
  input  logic [DATA_WIDTH-1:0] alpha,
  input  logic [DATA_WIDTH-1:0] gamma,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_q_new,
  output logic [AW-1:0]         out_best_action,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int DW = DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_ACTIONS - 1);
  localparam logic signed [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] QMIN = {1'b1, {(DW-1){1'b0}}};

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid/payload are held until then, ready may change freely.
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_MUL_G, S_MUL_A, S_WRITE, S_RESP
  } state_t;

  state_t state, state_n;

  logic signed [DW-1:0] qtab [NUM_STATES][NUM_ACTIONS];

  logic [SW-1:0]        s_r, ns_r;
  logic [AW-1:0]        a_r, cnt, best_r, best_out_r;
  logic signed [DW-1:0] r_r, alpha_r, gamma_r, max_r, q_sa, target_r, q_new_r;
  logic                 term_r;

  logic                 accept;
  logic signed [DW-1:0] rd_q;

  // Clamp a DW+1 bit sum: overflow shows as differing top two bits.
  function automatic logic signed [DW-1:0] sat_sum(input logic [DW:0] v);
    if (v[DW] != v[DW-1]) return v[DW] ? QMIN : QMAX;
    return v[DW-1:0];
  endfunction

  // Clamp a shifted 2*DW product: fits only if bits [2DW-1:DW-1] are all equal.
  function automatic logic signed [DW-1:0] sat_prod(input logic signed [2*DW-1:0] v);
    if (!((&v[2*DW-1:DW-1]) || !(|v[2*DW-1:DW-1]))) return v[2*DW-1] ? QMIN : QMAX;
    return v[DW-1:0];
  endfunction

  assign in_ready  = (state == S_IDLE) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign out_q_new = q_new_r;
  assign out_best_action = best_out_r;
  assign rd_q      = qtab[ns_r][cnt];

  // Gamma term and target. The shifted product is clamped to DW before the add.
  logic signed [2*DW-1:0] prod_g, shp_g, prod_a, shp_a;
  logic signed [DW-1:0]   gp, td, ap, target_n, q_new_n;
  logic [DW:0]            sum_g, diff_td, sum_q;

  always_comb begin
    prod_g   = gamma_r * max_r;
    shp_g    = prod_g >>> FRAC_BITS;
    gp       = sat_prod(shp_g);
    sum_g    = {r_r[DW-1], r_r} + {gp[DW-1], gp};
    target_n = term_r ? r_r : sat_sum(sum_g);

    diff_td  = {target_r[DW-1], target_r} - {q_sa[DW-1], q_sa};
    td       = sat_sum(diff_td);
    prod_a   = alpha_r * td;
    shp_a    = prod_a >>> FRAC_BITS;
    ap       = sat_prod(shp_a);
    sum_q    = {q_sa[DW-1], q_sa} + {ap[DW-1], ap};
    q_new_n  = sat_sum(sum_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_SCAN;
      S_SCAN:  if (cnt == LAST) state_n = S_MUL_G;
      S_MUL_G: state_n = S_MUL_A;
      S_MUL_A: state_n = S_WRITE;
      S_WRITE: state_n = S_RESP;
      S_RESP:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r <= '0; ns_r <= '0; a_r <= '0; r_r <= '0; term_r <= 1'b0;
      alpha_r <= '0; gamma_r <= '0; cnt <= '0; max_r <= '0; best_r <= '0;
      q_sa <= '0; target_r <= '0; q_new_r <= '0; best_out_r <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          s_r     <= in_state;
          a_r     <= in_action;
          ns_r    <= in_next_state;
          r_r     <= in_reward;
          term_r  <= in_terminal;
          alpha_r <= alpha;
          gamma_r <= gamma;
          cnt     <= '0;
        end
        S_SCAN: begin
          // Strict > keeps the lowest index on ties.
          if (cnt == '0) begin
            max_r  <= rd_q;
            best_r <= '0;
            q_sa   <= qtab[s_r][a_r];
          end else if (rd_q > max_r) begin
            max_r  <= rd_q;
            best_r <= cnt;
          end
          cnt <= cnt + 1'b1;
        end
        S_MUL_G: target_r <= target_n;
        S_MUL_A: begin
          q_new_r    <= q_new_n;
          best_out_r <= term_r ? '0 : best_r;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATES; i++)
        for (int j = 0; j < NUM_ACTIONS; j++) qtab[i][j] <= '0;
    end else if (state == S_IDLE && clear) begin
      for (int i = 0; i < NUM_STATES; i++)
        for (int j = 0; j < NUM_ACTIONS; j++) qtab[i][j] <= '0;
    end else if (state == S_WRITE) begin
      qtab[s_r][a_r] <= q_new_r;
    end
  end

endmodule

// File: tb/tb_q_update_engine.sv
// Directed table-driven bench for q_update_engine plus hand sequences for
// backpressure, clear and reset mid-scan.
module tb_q_update_engine;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NS = 16;
  localparam int NA = 4;
  localparam int SW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_state = '0;
  logic [AW-1:0] in_action = '0;
  logic [SW-1:0] in_next_state = '0;
  logic [DW-1:0] in_reward = '0;
  logic          in_terminal = 1'b0;
  logic [DW-1:0] alpha = '0;
  logic [DW-1:0] gamma = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_q_new;
  logic [AW-1:0] out_best_action;
  logic          busy;
  logic [2:0]    dbg_state;

  q_update_engine #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_STATES(NS), .NUM_ACTIONS(NA)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_action(in_action), .in_next_state(in_next_state),
    .in_reward(in_reward), .in_terminal(in_terminal), .alpha(alpha), .gamma(gamma),
    .out_valid(out_valid), .out_ready(out_ready), .out_q_new(out_q_new),
    .out_best_action(out_best_action), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s; int a; int ns; int r; bit term; int al; int ga; int exp_q; int exp_best;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[20];

  function automatic vec_t mk(int s, int a, int ns, int r, bit term, int al, int ga,
                              int eq, int eb);
    vec_t v;
    v.s = s; v.a = a; v.ns = ns; v.r = r; v.term = term; v.al = al; v.ga = ga;
    v.exp_q = eq; v.exp_best = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_state      = SW'(v.s);
    in_action     = AW'(v.a);
    in_next_state = SW'(v.ns);
    in_reward     = DW'(v.r);
    in_terminal   = v.term;
    alpha         = DW'(v.al);
    gamma         = DW'(v.ga);
  endtask

  task automatic send(input vec_t v, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    send(v, tag);
    wait_result(lat);
    chk({tag, "_latency"}, lat, NA + 3);
    chk({tag, "_q_new"}, $signed(out_q_new), v.exp_q);
    chk({tag, "_best"}, 32'(out_best_action), v.exp_best);
    ack(tag);
  endtask

  initial begin
    int lat;
    vec_t v;

    // {s, a, s', r, terminal, alpha, gamma, expected q_new, expected best}
    vecs[0]  = mk(1, 2, 3,    256, 0, 128, 128,    128, 0);
    vecs[1]  = mk(1, 2, 3,    256, 0, 128, 128,    192, 0);
    vecs[2]  = mk(3, 1, 0,    512, 1, 256,   0,    512, 0);
    vecs[3]  = mk(3, 2, 0,    512, 1, 256,   0,    512, 0);
    vecs[4]  = mk(0, 0, 3,      0, 0, 256, 128,    256, 1);
    vecs[5]  = mk(3, 0, 0,    512, 1, 256,   0,    512, 0);
    vecs[6]  = mk(3, 3, 0,    512, 1, 256,   0,    512, 0);
    vecs[7]  = mk(2, 1, 3,   -256, 1, 128, 128,   -128, 0);
    vecs[8]  = mk(6, 0, 0,  32767, 1, 256,   0,  32767, 0);
    vecs[9]  = mk(7, 0, 0,  32767, 1, 256,   0,  32767, 0);
    vecs[10] = mk(6, 0, 7,  32767, 0, 256, 256,  32767, 0);
    vecs[11] = mk(5, 0, 0, -32768, 1, 256,   0, -32768, 0);
    vecs[12] = mk(5, 1, 0, -32768, 1, 256,   0, -32768, 0);
    vecs[13] = mk(5, 2, 0, -32768, 1, 256,   0, -32768, 0);
    vecs[14] = mk(5, 3, 0, -32768, 1, 256,   0, -32768, 0);
    vecs[15] = mk(5, 0, 5, -32768, 0, 256, 256, -32768, 0);
    vecs[16] = mk(8, 0, 0,     -1, 1, 128,   0,     -1, 0);
    vecs[17] = mk(5, 1, 7,  32767, 0, 256, 256,     -1, 0);
    vecs[18] = mk(9, 0, 1,      0, 0, 256, 256,    192, 2);
    vecs[19] = mk(10, 0, 5,     0, 0, 256, 128,     -1, 1);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_q_new", 32'(out_q_new), 0);
    chk("rst_best", 32'(out_best_action), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while out_ready stays low.
    v = mk(11, 0, 0, 100, 1, 256, 0, 100, 0);
    send(v, "bp");
    wait_result(lat);
    chk("bp_latency", lat, NA + 3);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("bp_q_%0d", i), $signed(out_q_new), 100);
      chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 0);
      @(negedge clk);
    end
    ack("bp");

    // Clear in IDLE blocks acceptance that cycle and zeroes the table.
    @(negedge clk);
    drive(mk(1, 2, 1, 0, 0, 0, 0, 0, 0));
    clear = 1'b1;
    in_valid = 1'b1;
    #1 chk("clr_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_not_accepted", 32'(busy), 0);
    run_vec(mk(1, 2, 1, 0, 0, 0, 0, 0, 0), "clr_q12");
    run_vec(mk(11, 0, 11, 0, 0, 0, 0, 0, 0), "clr_q110");

    // Reset mid-scan aborts and wipes the table.
    run_vec(mk(4, 1, 0, 300, 1, 256, 0, 300, 0), "pre_rst");
    send(mk(4, 1, 4, 1000, 0, 256, 256, 0, 0), "rst_req");
    @(negedge clk);
    chk("rst_req_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_q", 32'(out_q_new), 0);
    chk("mid_rst_best", 32'(out_best_action), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(4, 1, 4, 0, 0, 0, 0, 0, 0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
